regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Next-generation decode-stage register file: parametrised width/depth, 2 read ports,
//  2 write ports, per-register clear and clear-all, and a busy scoreboard used by
//  hazard detection. Sits in decode; read data feeds the ID/EX pipeline register,
//  write ports are driven from writeback (WB) and a second retire path.
// PARAMETERS
//  N       16  data width per register (bits)
//  ADDR_W  3   address width; DEPTH = 2**ADDR_W registers
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       asynchronous active-low reset
//  clr_all    in   1       synchronous clear of all registers and busy bits
//  clr_one    in   1       synchronous clear of register wr_addr_0 (data and busy)
//  rd_addr_1  in   ADDR_W  read port 1 address
//  rd_addr_2  in   ADDR_W  read port 2 address
//  rd_data_1  out  N       read port 1 data (registered)
//  rd_data_2  out  N       read port 2 data (registered)
//  rd_busy_1  out  1       busy bit of rd_addr_1 (registered, same timing as rd_data_1)
//  rd_busy_2  out  1       busy bit of rd_addr_2 (registered)
//  we_0       in   1       write enable, port 0 (WB)
//  wr_addr_0  in   ADDR_W  write address, port 0
//  wr_data_0  in   N       write data, port 0
//  we_1       in   1       write enable, port 1 (retire)
//  wr_addr_1  in   ADDR_W  write address, port 1
//  wr_data_1  in   N       write data, port 1
//  mark_en    in   1       set busy bit of mark_addr (instruction issued with dest)
//  mark_addr  in   ADDR_W  destination register to mark busy
// BEHAVIOUR
//  - Reset (rst=0, async): all registers, busy bits, rd_data_*, rd_busy_* -> 0.
//  - Writes: at posedge; priority clr_all > clr_one > write ports.
//  - clr_all: every register and busy bit -> 0; other writes/marks that cycle ignored.
//  - clr_one: register[wr_addr_0] and its busy bit -> 0; we_0 ignored; we_1 and
//    mark_en still act unless they target wr_addr_0 (clear wins).
//  - Both write ports to same address: port 0 wins; port 1 dropped.
//  - A write on either port clears the busy bit of its address.
//  - mark_en sets busy[mark_addr]; mark and write to same address same cycle -> busy=1
//    (new producer wins), data still written.
//  - Reads: rd_data_x/rd_busy_x sampled at posedge, 1-cycle latency, addresses
//    presented in cycle t appear at outputs in cycle t+1; no read enable.
//  - Read of an address being written/cleared/marked in the same edge: see
//    CONFIGURATION. Both read ports may use same address; identical results.
//  - Address range is full 2**ADDR_W; no out-of-range case. No hardwired-zero register.
//  - Reset asserted mid-operation overrides everything immediately; first posedge after
//    release behaves normally.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-edge read of an address being updated returns the
//    post-update value (written data per priority above, 0 if cleared; busy reflects
//    post-update busy). Write-then-read in one cycle, replaces half-cycle timing.
//  REGFILE_BYPASS_EN undefined: same-edge read returns pre-update value (data and
//    busy); new value visible one cycle later.
// TESTING
//  1 Reset: rst=0 mid-run with regs nonzero -> all rd_data/rd_busy 0 immediately;
//    after release, read all 8 addrs -> 0.
//  2 Write/read: we_0 addr 3 data 16'hA5A5, next cycle rd_addr_1=3 -> rd_data_1=A5A5
//    one cycle later; rd_addr_2=3 same -> rd_data_2=A5A5.
//  3 Port conflict: we_0 & we_1 both addr 5, data 16'h1111 / 16'h2222 -> reg5=16'h1111.
//  4 Scoreboard: mark_en addr 2 -> rd_busy=1; we_1 addr 2 data 7 -> busy 0, data 7;
//    mark+write addr 2 same cycle -> busy stays 1, data updated.
//  5 Clears: fill regs 1..7, clr_one wr_addr_0=4 -> reg4=0, others kept; clr_all with
//    we_1 active -> all 0, write dropped, all busy 0.
//  6 Bypass: reg6=16'h0001, write 16'hBEEF to 6 while rd_addr_1=6 -> next rd_data_1 =
//    BEEF with REGFILE_BYPASS_EN, 0001 without; run bench under both builds.

Source files
------------

// File: rtl/regfile_mp.sv
// Decode-stage register file: 2 registered read ports, 2 write ports, clears and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-edge reads return post-update data/busy instead of pre-update.
module regfile_mp #(
  parameter int N      = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic              clr_one,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [N-1:0]      rd_data_1,
  output logic [N-1:0]      rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [N-1:0]      wr_data_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [N-1:0]      wr_data_1,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0]     data_reg  [DEPTH];
  logic [N-1:0]     data_next [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  logic [DEPTH-1:0] clr_hit;
  logic [DEPTH-1:0] wr0_hit;
  logic [DEPTH-1:0] wr1_hit;
  logic [DEPTH-1:0] mark_hit;

  // Per-register decode; port 1 yields to port 0 on a shared address, and a clear beats both.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign clr_hit[gi]  = clr_all | (clr_one & (wr_addr_0 == ADDR_W'(gi)));
      assign wr0_hit[gi]  = we_0 & ~clr_one & (wr_addr_0 == ADDR_W'(gi));
      assign wr1_hit[gi]  = we_1 & ~wr0_hit[gi] & (wr_addr_1 == ADDR_W'(gi));
      assign mark_hit[gi] = mark_en & (mark_addr == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_next[i] = data_reg[i];
      busy_next[i] = busy_reg[i];
      if (clr_hit[i]) begin
        data_next[i] = '0;
        busy_next[i] = 1'b0;
      end else begin
        if (wr0_hit[i]) begin
          data_next[i] = wr_data_0;
          busy_next[i] = 1'b0;
        end else if (wr1_hit[i]) begin
          data_next[i] = wr_data_1;
          busy_next[i] = 1'b0;
        end
        // A newly issued producer owns the register even if an older result lands now.
        if (mark_hit[i]) begin
          busy_next[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i] <= data_next[i];
      end
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_1 <= '0;
      rd_data_2 <= '0;
      rd_busy_1 <= 1'b0;
      rd_busy_2 <= 1'b0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      rd_data_1 <= data_next[rd_addr_1];
      rd_data_2 <= data_next[rd_addr_2];
      rd_busy_1 <= busy_next[rd_addr_1];
      rd_busy_2 <= busy_next[rd_addr_2];
`else
      rd_data_1 <= data_reg[rd_addr_1];
      rd_data_2 <= data_reg[rd_addr_2];
      rd_busy_1 <= busy_reg[rd_addr_1];
      rd_busy_2 <= busy_reg[rd_addr_2];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; builds with or without REGFILE_BYPASS_EN.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clr_all;
  logic        clr_one;
  logic [2:0]  rd_addr_1;
  logic [2:0]  rd_addr_2;
  logic [15:0] rd_data_1;
  logic [15:0] rd_data_2;
  logic        rd_busy_1;
  logic        rd_busy_2;
  logic        we_0;
  logic [2:0]  wr_addr_0;
  logic [15:0] wr_data_0;
  logic        we_1;
  logic [2:0]  wr_addr_1;
  logic [15:0] wr_data_1;
  logic        mark_en;
  logic [2:0]  mark_addr;

  int tests_run;
  int tests_failed;

  regfile_mp #(.N(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_all   (clr_all),
    .clr_one   (clr_one),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .rd_busy_1 (rd_busy_1),
    .rd_busy_2 (rd_busy_2),
    .we_0      (we_0),
    .wr_addr_0 (wr_addr_0),
    .wr_data_0 (wr_data_0),
    .we_1      (we_1),
    .wr_addr_1 (wr_addr_1),
    .wr_data_1 (wr_data_1),
    .mark_en   (mark_en),
    .mark_addr (mark_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs change just after a falling edge; outputs are checked at the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    clr_all = 0; clr_one = 0;
    we_0 = 0; wr_addr_0 = 0; wr_data_0 = 0;
    we_1 = 0; wr_addr_1 = 0; wr_data_1 = 0;
    mark_en = 0; mark_addr = 0;
  endtask

  task automatic write0(input logic [2:0] a, input logic [15:0] d);
    we_0 = 1; wr_addr_0 = a; wr_data_0 = d;
    tick();
    idle();
  endtask

  task automatic read2(input logic [2:0] a1, input logic [2:0] a2);
    rd_addr_1 = a1; rd_addr_2 = a2;
    tick();
  endtask

  logic [15:0] exp_byp_data;
  logic        exp_byp_busy;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 0;
    rd_addr_1 = 0;
    rd_addr_2 = 0;
    idle();
    tick();
    tick();
    check_eq("reset_rd_data_1", 32'(rd_data_1), 32'h0);
    check_eq("reset_rd_data_2", 32'(rd_data_2), 32'h0);
    check_eq("reset_rd_busy_1", 32'(rd_busy_1), 32'h0);
    check_eq("reset_rd_busy_2", 32'(rd_busy_2), 32'h0);
    rst = 1;
    tick();

    // Write then read on both ports
    write0(3'd3, 16'hA5A5);
    read2(3'd3, 3'd3);
    check_eq("wr_rd_port1", 32'(rd_data_1), 32'hA5A5);
    check_eq("wr_rd_port2", 32'(rd_data_2), 32'hA5A5);

    // Both write ports on the same address: port 0 wins
    we_0 = 1; wr_addr_0 = 3'd5; wr_data_0 = 16'h1111;
    we_1 = 1; wr_addr_1 = 3'd5; wr_data_1 = 16'h2222;
    tick();
    idle();
    read2(3'd5, 3'd3);
    check_eq("conflict_reg5", 32'(rd_data_1), 32'h1111);
    check_eq("conflict_reg3_kept", 32'(rd_data_2), 32'hA5A5);

    // Scoreboard
    mark_en = 1; mark_addr = 3'd2;
    tick();
    idle();
    read2(3'd2, 3'd2);
    check_eq("mark_busy1", 32'(rd_busy_1), 32'h1);
    check_eq("mark_busy2", 32'(rd_busy_2), 32'h1);
    we_1 = 1; wr_addr_1 = 3'd2; wr_data_1 = 16'h0007;
    tick();
    idle();
    read2(3'd2, 3'd2);
    check_eq("wr1_clears_busy", 32'(rd_busy_1), 32'h0);
    check_eq("wr1_data", 32'(rd_data_1), 32'h0007);
    mark_en = 1; mark_addr = 3'd2;
    we_1 = 1; wr_addr_1 = 3'd2; wr_data_1 = 16'h0009;
    tick();
    idle();
    read2(3'd2, 3'd2);
    check_eq("mark_wr_busy", 32'(rd_busy_1), 32'h1);
    check_eq("mark_wr_data", 32'(rd_data_2), 32'h0009);

    // Clears
    for (int i = 1; i < 8; i++) write0(3'(i), 16'h1000 + 16'(i));
    mark_en = 1; mark_addr = 3'd4;
    tick();
    idle();
    clr_one = 1; wr_addr_0 = 3'd4;
    we_0 = 1; wr_data_0 = 16'hFFFF;
    we_1 = 1; wr_addr_1 = 3'd5; wr_data_1 = 16'h5555;
    mark_en = 1; mark_addr = 3'd1;
    tick();
    idle();
    read2(3'd4, 3'd4);
    check_eq("clr_one_data", 32'(rd_data_1), 32'h0);
    check_eq("clr_one_busy", 32'(rd_busy_2), 32'h0);
    read2(3'd5, 3'd3);
    check_eq("clr_one_wr1_acts", 32'(rd_data_1), 32'h5555);
    check_eq("clr_one_reg3_kept", 32'(rd_data_2), 32'h1003);
    read2(3'd1, 3'd7);
    check_eq("clr_one_mark_acts", 32'(rd_busy_1), 32'h1);
    check_eq("clr_one_reg7_kept", 32'(rd_data_2), 32'h1007);
    clr_all = 1;
    we_1 = 1; wr_addr_1 = 3'd7; wr_data_1 = 16'h7777;
    mark_en = 1; mark_addr = 3'd3;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      read2(3'(i), 3'(i));
      check_eq($sformatf("clr_all_data_%0d", i), 32'(rd_data_1), 32'h0);
      check_eq($sformatf("clr_all_busy_%0d", i), 32'(rd_busy_2), 32'h0);
    end

    // Same-edge read of a register being written / marked
    write0(3'd6, 16'h0001);
`ifdef REGFILE_BYPASS_EN
    exp_byp_data = 16'hBEEF;
    exp_byp_busy = 1'b1;
`else
    exp_byp_data = 16'h0001;
    exp_byp_busy = 1'b0;
`endif
    we_0 = 1; wr_addr_0 = 3'd6; wr_data_0 = 16'hBEEF;
    rd_addr_1 = 3'd6; rd_addr_2 = 3'd6;
    tick();
    idle();
    check_eq("same_edge_data", 32'(rd_data_1), 32'(exp_byp_data));
    tick();
    check_eq("after_edge_data", 32'(rd_data_2), 32'hBEEF);
    mark_en = 1; mark_addr = 3'd6;
    tick();
    idle();
    check_eq("same_edge_busy", 32'(rd_busy_2), 32'(exp_byp_busy));
    tick();
    check_eq("after_edge_busy", 32'(rd_busy_1), 32'h1);

    // Asynchronous reset mid-run
    #2;
    rst = 0;
    #1;
    check_eq("async_rst_data_1", 32'(rd_data_1), 32'h0);
    check_eq("async_rst_data_2", 32'(rd_data_2), 32'h0);
    check_eq("async_rst_busy_1", 32'(rd_busy_1), 32'h0);
    check_eq("async_rst_busy_2", 32'(rd_busy_2), 32'h0);
    tick();
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      read2(3'(i), 3'(7 - i));
      check_eq($sformatf("post_rst_data_%0d", i), 32'(rd_data_1), 32'h0);
      check_eq($sformatf("post_rst_busy_%0d", i), 32'(rd_busy_1), 32'h0);
    end

    // Normal operation after release
    write0(3'd0, 16'h1234);
    read2(3'd0, 3'd0);
    check_eq("post_rst_write", 32'(rd_data_2), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
